// File: rtl/quad_step_if.sv
// rtl/quad_step_if.sv - quadrature inputs and step/direction/error outputs
interface quad_step_if;
  logic a_in;
  logic b_in;
  logic err_clr;
  logic step;
  logic up_down;
  logic err;

  modport master (
    output a_in, b_in, err_clr,
    input  step, up_down, err
  );

  modport slave (
    input  a_in, b_in, err_clr,
    output step, up_down, err
  );
endinterface

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - synchronised, glitch-filtered quadrature decoder
module quad_step_decoder #(
  parameter int FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  quad_step_if.slave  bus
);

  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

  logic a_m, a_s, b_m, b_s;
  logic a_f, b_f;
  logic [3:0] a_cnt, b_cnt;
  logic [1:0] prev;
  logic step_r, up_down_r, err_r;
  logic [1:0] cur;
  logic fwd, bwd, ill;

  // two-flop synchronisers, nothing between the stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_m <= 1'b0;
      a_s <= 1'b0;
      b_m <= 1'b0;
      b_s <= 1'b0;
    end else begin
      a_m <= bus.a_in;
      a_s <= a_m;
      b_m <= bus.b_in;
      b_s <= b_m;
    end
  end

  // channel A filter: accept a new level only after FILTER_LEN mismatched cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_f   <= 1'b0;
      a_cnt <= 4'd0;
    end else if (a_s == a_f) begin
      a_cnt <= 4'd0;
    end else if (a_cnt == LAST) begin
      a_f   <= a_s;
      a_cnt <= 4'd0;
    end else begin
      a_cnt <= a_cnt + 4'd1;
    end
  end

  // channel B filter, identical to channel A
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_f   <= 1'b0;
      b_cnt <= 4'd0;
    end else if (b_s == b_f) begin
      b_cnt <= 4'd0;
    end else if (b_cnt == LAST) begin
      b_f   <= b_s;
      b_cnt <= 4'd0;
    end else begin
      b_cnt <= b_cnt + 4'd1;
    end
  end

  assign cur = {a_f, b_f};

  // classify previous->current pair: Gray-code forward, backward or two-bit jump
  always_comb begin
    fwd = 1'b0;
    bwd = 1'b0;
    ill = 1'b0;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: bwd = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: ill = 1'b1;
      default: ;
    endcase
  end

  // register decode results; an illegal jump beats a simultaneous err_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev      <= 2'b00;
      step_r    <= 1'b0;
      up_down_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      prev   <= cur;
      step_r <= fwd | bwd;
      if (fwd) begin
        up_down_r <= 1'b1;
      end else if (bwd) begin
        up_down_r <= 1'b0;
      end
      if (ill) begin
        err_r <= 1'b1;
      end else if (bus.err_clr) begin
        err_r <= 1'b0;
      end
    end
  end

  assign bus.step    = step_r;
  assign bus.up_down = up_down_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - directed self-checking bench for quad_step_decoder
module tb_quad_step_decoder;

  logic clk;
  logic reset;
  quad_step_if bus ();

  quad_step_decoder #(.FILTER_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // observation window results
  logic [63:0] step_log;
  int          step_cnt;
  int          first_idx;
  int          ud_bad;
  logic        ud_last;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "timeout");
  end

  // run n cycles sampling on the falling edge; index i = rising edges since the call
  task automatic run_cycles(input int n);
    step_log  = '0;
    step_cnt  = 0;
    first_idx = -1;
    ud_bad    = 0;
    ud_last   = bus.up_down;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.step) begin
        step_cnt++;
        if (first_idx < 0) first_idx = i;
        if (i < 64) step_log[i] = 1'b1;
      end else if (bus.up_down !== ud_last) begin
        ud_bad++;
      end
      ud_last = bus.up_down;
    end
  endtask

  task automatic drive_ab(input logic [1:0] v);
    bus.a_in = v[1];
    bus.b_in = v[0];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.step, bus.up_down, bus.err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000", {bus.step, bus.up_down, bus.err});
    end
    reset = 1'b0;
    run_cycles(50);
    n_tests++;
    if (step_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_steps: got %0d, required 0", step_cnt);
    end
    n_tests++;
    if ({bus.up_down, bus.err} !== 2'b00 || ud_bad !== 0) begin
      n_fail++;
      $display("FAIL idle_state: got ud/err %b ud_changes %0d, required 00 and 0",
               {bus.up_down, bus.err}, ud_bad);
    end
  endtask

  task automatic test_sequence(input logic up);
    logic [1:0] seq [4];
    if (up) seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    else    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int p = 0; p < 4; p++) begin
      drive_ab(seq[p]);
      run_cycles(20);
      n_tests++;
      if (step_cnt !== 1) begin
        n_fail++;
        $display("FAIL seq%0d_phase%0d_count: got %0d steps, required 1", up, p, step_cnt);
      end
      n_tests++;
      if (first_idx < 6 || first_idx > 8) begin
        n_fail++;
        $display("FAIL seq%0d_phase%0d_latency: got %0d, required 7+-1", up, p, first_idx);
      end
      n_tests++;
      if (bus.up_down !== up || bus.err !== 1'b0 || ud_bad !== 0) begin
        n_fail++;
        $display("FAIL seq%0d_phase%0d_dir: got ud %b err %b ud_changes %0d, required ud %b err 0 and 0",
                 up, p, bus.up_down, bus.err, ud_bad, up);
      end
    end
  endtask

  task automatic test_glitch;
    bus.a_in = 1'b1;
    repeat (3) @(negedge clk);
    bus.a_in = 1'b0;
    run_cycles(20);
    n_tests++;
    if (step_cnt !== 0) begin
      n_fail++;
      $display("FAIL glitch3_steps: got %0d, required 0", step_cnt);
    end
    bus.a_in = 1'b1;
    @(negedge clk);
    bus.a_in = 1'b0;
    run_cycles(20);
    n_tests++;
    if (step_cnt !== 0) begin
      n_fail++;
      $display("FAIL glitch1_steps: got %0d, required 0", step_cnt);
    end
    drive_ab(2'b10);
    run_cycles(20);
    n_tests++;
    if (step_cnt !== 1 || first_idx !== 7 || bus.up_down !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_then_edge: got cnt %0d at %0d ud %b, required 1 at 7 ud 0",
               step_cnt, first_idx, bus.up_down);
    end
    drive_ab(2'b00);
    run_cycles(20);
    n_tests++;
    if (step_cnt !== 1 || bus.up_down !== 1'b1 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_return: got cnt %0d ud %b err %b, required 1 1 0",
               step_cnt, bus.up_down, bus.err);
    end
  endtask

  task automatic test_error;
    drive_ab(2'b11);
    run_cycles(20);
    n_tests++;
    if (step_cnt !== 0 || bus.err !== 1'b1 || bus.up_down !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_00_11: got cnt %0d err %b ud %b, required 0 1 1",
               step_cnt, bus.err, bus.up_down);
    end
    run_cycles(10);
    n_tests++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", bus.err);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b, required 0", bus.err);
    end
    drive_ab(2'b00);
    repeat (6) @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_before_jump: got %b, required 0", bus.err);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.err !== 1'b1 || bus.step !== 1'b0) begin
      n_fail++;
      $display("FAIL set_beats_clear: got err %b step %b, required 1 0", bus.err, bus.step);
    end
    run_cycles(10);
    n_tests++;
    if (step_cnt !== 0 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_11_00: got cnt %0d err %b, required 0 1", step_cnt, bus.err);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear2: got %b, required 0", bus.err);
    end
  endtask

  task automatic test_reset_mid;
    drive_ab(2'b10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_ab(2'b00);
    @(negedge clk);
    n_tests++;
    if ({bus.step, bus.up_down, bus.err} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b, required 000", {bus.step, bus.up_down, bus.err});
    end
    @(negedge clk);
    reset = 1'b0;
    run_cycles(20);
    n_tests++;
    if (step_cnt !== 0 || bus.up_down !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_mid_reset: got cnt %0d ud %b err %b, required 0 0 0",
               step_cnt, bus.up_down, bus.err);
    end
    drive_ab(2'b01);
    run_cycles(20);
    n_tests++;
    if (step_cnt !== 1 || first_idx !== 7 || bus.up_down !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_after_reset: got cnt %0d at %0d ud %b, required 1 at 7 ud 1",
               step_cnt, first_idx, bus.up_down);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_log;
    exp_log = 64'h0000_0000_0000_00C0;
    bus.b_in = 1'b0;
    @(negedge clk);
    bus.a_in = 1'b1;
    run_cycles(20);
    n_tests++;
    if (step_log !== exp_log) begin
      n_fail++;
      $display("FAIL back_to_back_pulses: got %h, required %h", step_log, exp_log);
    end
    n_tests++;
    if (bus.up_down !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_dir: got ud %b err %b, required 0 0", bus.up_down, bus.err);
    end
  endtask

  initial begin
    test_reset();
    test_sequence(1'b1);
    test_sequence(1'b0);
    test_glitch();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
